one_counter_fsm: RTL and testbench
==================================

# one_counter_fsm

Population-count engine that counts the 1 bits in a WIDTH-bit input word. It processes one bit per clock under a small state machine. It is a single parameterized block covering both the 16-bit variant (WIDTH=16, start tied high) and the 32-bit variant (WIDTH=32, start driven by the controller). It sits behind a simple start/done handshake: a controller presents a word, asserts start, waits for done, then reads the count.

## Interface
Parameters:
- WIDTH, default 16: width of i_data and o_data. Legal values are 16 and 32; any value ≥ 2 must work.

Ports:
- i_clk, input, 1: single clock. All state changes on the rising edge.
- i_rst, input, 1: reset. Asynchronous, active-low. 0 forces reset immediately; release is sampled on i_clk.
- i_start, input, 1: start request. Level-sensitive and sampled in IDLE. Tie to 1 for auto-start after reset.
- i_data, input, WIDTH: word to count. Sampled only on the start edge.
- o_data, output, WIDTH: number of 1 bits in the captured word, zero-extended. Registered.
- o_done, output, 1: result valid. Registered.

## Operation
States are IDLE, COUNT and DONE.

IDLE:
- o_done=0.
- If i_start=1 at the clock edge:
  - shift register ← i_data
  - accumulator ← 0
  - bit index ← 0
  - next state COUNT.
- Otherwise stay in IDLE.

COUNT, on each edge:
- accumulator ← accumulator + shift[0]
- shift ← shift >> 1
- bit index ← index + 1
- When index = WIDTH-1 on this edge:
  - o_data ← accumulator + shift[0]
  - o_done ← 1
  - next state DONE.
- Exactly WIDTH edges are spent in COUNT regardless of data. There is no early exit.

DONE:
- o_done=1 and o_data holds the result.
- If i_start=1, remain in DONE. Holding start high never retriggers.
- If i_start=0, go to IDLE:
  - o_done ← 0
  - o_data keeps its last result until the next result overwrites it.

Arithmetic and width:
- Accumulator is WIDTH bits wide, so no overflow is possible (max value is WIDTH).
- The upper bits of o_data are always 0 beyond ceil(log2(WIDTH+1)) bits.

Boundaries:
- All-zero word gives 0. All-ones word gives WIDTH.
- i_data changes after the start edge are ignored.
- i_start changes during COUNT are ignored.
- Reset asserted in any state, including mid-COUNT:
  - aborts the operation
  - clears o_done and o_data to 0
  - returns to IDLE.
- Back-to-back operation: deassert i_start for at least one edge in DONE, then reassert it in IDLE.
- With i_start tied high, a new count begins only after a reset pulse.

## Timing
- Reset values: state=IDLE, o_data=0, o_done=0, shift/accumulator/index=0.
- Define edge E0 as the first rising edge with the FSM in IDLE, i_start=1 and i_rst=1. That edge loads the word.
- Edges E1..EWIDTH perform the counting.
- o_done rises and o_data is valid after edge EWIDTH. Total latency is WIDTH+1 edges from E0: 17 for WIDTH=16, 33 for WIDTH=32.
- o_data and o_done change on the same edge. There is never a done cycle with a stale count.
- o_done stays high until the first edge in DONE with i_start=0. It drops one edge after start is released.

## Test plan
- WIDTH=16, i_start=1, reset pulse, then i_data=0x000F → o_done after 17 edges, o_data=4. Repeat with a reset pulse between words:
  - 0xF0F0 → 8
  - 0xFFFF → 16
  - 0x0000 → 0
- WIDTH=32, i_start=1, i_data=0x0000FFFF → o_data=16 at edge 33. Then 0xFFFFFFFF → 32, and 0x0000F0F1 → 9.
- Start held high through DONE → o_done stays 1 and o_data is stable for 20+ cycles with no recount. Then drop i_start → o_done=0 one edge later, state IDLE.
- Change i_data every cycle during COUNT after loading 0x00FF (WIDTH=16) → result is still 8.
- Assert i_rst=0 at edge 5 of COUNT → o_done=0 and o_data=0 immediately, without waiting for a clock edge. After release with start=1, a fresh count is produced 17 edges later.
- Two words back-to-back via start handshake (0x0001, then 0x8000) → both yield 1, each after 17 edges from its start edge.

Source files
------------

// File: rtl/one_counter_fsm_if.sv
// Start/done handshake bundle between a controller and the population-count engine.
// The controller drives start and the word; the engine returns the count and done.
interface one_counter_fsm_if #(
  parameter int unsigned WIDTH = 16
);
  logic             i_start;
  logic [WIDTH-1:0] i_data;
  logic [WIDTH-1:0] o_data;
  logic             o_done;

  modport master (
    output i_start,
    output i_data,
    input  o_data,
    input  o_done
  );

  modport slave (
    input  i_start,
    input  i_data,
    output o_data,
    output o_done
  );
endinterface

// File: rtl/one_counter_fsm.sv
// Bit-serial population count: loads a word on start, then spends exactly WIDTH
// cycles shifting it out LSB-first while accumulating the ones.
module one_counter_fsm #(
  parameter int unsigned WIDTH = 16
) (
  input logic           i_clk,
  input logic           i_rst,
  one_counter_fsm_if.slave bus
);

  localparam int unsigned IdxW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StCount, StDone} state_e;

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  shift_q, shift_d;
  logic [WIDTH-1:0]  acc_q,   acc_d;
  logic [IdxW-1:0]   idx_q,   idx_d;
  logic [WIDTH-1:0]  data_q,  data_d;
  logic              done_q,  done_d;
  logic [WIDTH-1:0]  lsb_ext;

  assign lsb_ext = {{(WIDTH-1){1'b0}}, shift_q[0]};

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    acc_d   = acc_q;
    idx_d   = idx_q;
    data_d  = data_q;
    done_d  = done_q;
    unique case (state_q)
      StIdle: begin
        done_d = 1'b0;
        if (bus.i_start) begin
          shift_d = bus.i_data;
          acc_d   = '0;
          idx_d   = '0;
          state_d = StCount;
        end
      end
      StCount: begin
        acc_d   = acc_q + lsb_ext;
        shift_d = shift_q >> 1;
        idx_d   = idx_q + 1'b1;
        // Final bit folds straight into the result so done never shows a stale count.
        if (idx_q == LastIdx) begin
          data_d  = acc_q + lsb_ext;
          done_d  = 1'b1;
          state_d = StDone;
        end
      end
      StDone: begin
        if (!bus.i_start) begin
          done_d  = 1'b0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q <= StIdle;
      shift_q <= '0;
      acc_q   <= '0;
      idx_q   <= '0;
      data_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      acc_q   <= acc_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      done_q  <= done_d;
    end
  end

  assign bus.o_data = data_q;
  assign bus.o_done = done_q;

endmodule

// File: tb/tb_one_counter_fsm.sv
// Directed plus randomized checks of the 16- and 32-bit popcount engines against
// a popcount reference and the WIDTH+1 edge latency rule.
module tb_one_counter_fsm;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst16_n;
  logic rst32_n;

  one_counter_fsm_if #(.WIDTH(16)) if16 ();
  one_counter_fsm_if #(.WIDTH(32)) if32 ();

  one_counter_fsm #(.WIDTH(16)) u16 (
    .i_clk (clk),
    .i_rst (rst16_n),
    .bus   (if16.slave)
  );

  one_counter_fsm #(.WIDTH(32)) u32 (
    .i_clk (clk),
    .i_rst (rst32_n),
    .bus   (if32.slave)
  );

  int tests = 0;
  int fails = 0;

  function automatic logic [31:0] popcount(input logic [31:0] w, input int width);
    logic [31:0] n = 0;
    for (int i = 0; i < width; i++) n += {31'd0, w[i]};
    return n;
  endfunction

  function automatic logic [31:0] dout(input bit w32);
    return w32 ? if32.o_data : {16'h0, if16.o_data};
  endfunction

  function automatic logic [31:0] dn(input bit w32);
    return w32 ? {31'd0, if32.o_done} : {31'd0, if16.o_done};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic set_in(input bit w32, input bit start, input logic [31:0] data);
    if (w32) begin
      if32.i_start = start;
      if32.i_data  = data;
    end else begin
      if16.i_start = start;
      if16.i_data  = data[15:0];
    end
  endtask

  task automatic set_rst(input bit w32, input logic v);
    if (w32) rst32_n = v;
    else     rst16_n = v;
  endtask

  // Pulse reset away from the clock edge; outputs must clear without an edge.
  task automatic reset_pulse(input bit w32, input string tag);
    @(negedge clk);
    set_rst(w32, 1'b0);
    #1;
    check({tag, " rst done"}, dn(w32), 0);
    check({tag, " rst data"}, dout(w32), 0);
    @(negedge clk);
    set_rst(w32, 1'b1);
  endtask

  // Presents a word with start high; the next rising edge is E0.
  task automatic run_word(input bit w32, input logic [31:0] word, input bit scramble,
                          input string tag);
    int width = w32 ? 32 : 16;
    int lat = 0;
    set_in(w32, 1'b1, word);
    for (int e = 1; e <= 200; e++) begin
      @(posedge clk);
      @(negedge clk);
      if (dn(w32) == 1) begin
        lat = e;
        break;
      end
      if (scramble) set_in(w32, 1'b1, $urandom);
    end
    check({tag, " latency"}, lat, width + 1);
    check({tag, " count"}, dout(w32), popcount(word, width));
  endtask

  task automatic drop_start(input bit w32, input string tag);
    set_in(w32, 1'b0, 32'h0);
    @(posedge clk);
    @(negedge clk);
    check({tag, " done drop"}, dn(w32), 0);
  endtask

  initial begin
    logic [31:0] held;
    logic [31:0] w;
    rst16_n = 1'b0;
    rst32_n = 1'b0;
    set_in(1'b0, 1'b1, 32'h0);
    set_in(1'b1, 1'b1, 32'h0);
    #12;
    check("reset done16", dn(1'b0), 0);
    check("reset data16", dout(1'b0), 0);
    check("reset done32", dn(1'b1), 0);
    check("reset data32", dout(1'b1), 0);

    // Start tied high, reset pulse between words.
    set_in(1'b0, 1'b1, 32'h000F); reset_pulse(1'b0, "w000F"); run_word(1'b0, 32'h000F, 1'b0, "w000F");
    set_in(1'b0, 1'b1, 32'hF0F0); reset_pulse(1'b0, "wF0F0"); run_word(1'b0, 32'hF0F0, 1'b0, "wF0F0");
    set_in(1'b0, 1'b1, 32'hFFFF); reset_pulse(1'b0, "wFFFF"); run_word(1'b0, 32'hFFFF, 1'b0, "wFFFF");

    // Holding start high in DONE must not retrigger.
    held = dout(1'b0);
    for (int i = 0; i < 22; i++) begin
      @(posedge clk);
      @(negedge clk);
      check("hold done", dn(1'b0), 1);
      check("hold data", dout(1'b0), 16);
    end
    drop_start(1'b0, "hold");
    check("idle keeps data", dout(1'b0), held);

    set_in(1'b0, 1'b1, 32'h0000); reset_pulse(1'b0, "w0000"); run_word(1'b0, 32'h0000, 1'b0, "w0000");

    // Data changes after the load edge are ignored.
    set_in(1'b0, 1'b1, 32'h00FF); reset_pulse(1'b0, "scr"); run_word(1'b0, 32'h00FF, 1'b1, "scramble");

    // Back-to-back through the handshake.
    drop_start(1'b0, "b2b0");
    run_word(1'b0, 32'h0001, 1'b0, "b2b 0001");
    drop_start(1'b0, "b2b1");
    run_word(1'b0, 32'h8000, 1'b0, "b2b 8000");
    drop_start(1'b0, "b2b2");
    check("idle keeps 1", dout(1'b0), 1);

    // Asynchronous abort mid-count while o_data still holds the previous result.
    set_in(1'b0, 1'b1, 32'hFFFF);
    repeat (6) @(posedge clk);
    #1 rst16_n = 1'b0;
    #1;
    check("abort done", dn(1'b0), 0);
    check("abort data", dout(1'b0), 0);
    @(negedge clk);
    set_in(1'b0, 1'b1, 32'hF0F0);
    rst16_n = 1'b1;
    run_word(1'b0, 32'hF0F0, 1'b0, "post abort");

    for (int i = 0; i < 6; i++) begin
      drop_start(1'b0, "rnd16");
      w = $urandom;
      run_word(1'b0, {16'h0, w[15:0]}, i[0], "rnd16");
    end

    // 32-bit variant.
    set_in(1'b1, 1'b1, 32'h0000FFFF); reset_pulse(1'b1, "w32a"); run_word(1'b1, 32'h0000FFFF, 1'b0, "w32 0000FFFF");
    set_in(1'b1, 1'b1, 32'hFFFFFFFF); reset_pulse(1'b1, "w32b"); run_word(1'b1, 32'hFFFFFFFF, 1'b0, "w32 FFFFFFFF");
    set_in(1'b1, 1'b1, 32'h0000F0F1); reset_pulse(1'b1, "w32c"); run_word(1'b1, 32'h0000F0F1, 1'b0, "w32 0000F0F1");

    for (int i = 0; i < 6; i++) begin
      drop_start(1'b1, "rnd32");
      w = $urandom;
      run_word(1'b1, w, i[0], "rnd32");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
